axis_rr_arbiter: RTL

- Shares one registered AXI-Stream-style output channel between NUM_INPUTS packet sources.
- Round-robin arbitration at packet granularity: a granted input keeps the channel until its beat with last=1 is accepted.
- Sits in front of the single output path (DMA writer / USB FIFO) that collects traffic from several producers.
- Output is a one-deep register slice, ready = ~valid | m_ready.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_rr_pick.sv | 28 ++
 rtl/axis_rr_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter: FSM encoding,
// packet-counter width and a constant clog2 used to size source indices.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_WIDTH = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// above ptr, wrapping modulo NUM_INPUTS.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    localparam int SEL_WIDTH  = clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SEL_WIDTH-1:0]  ptr,
    output logic                  any,
    output logic [SEL_WIDTH-1:0]  index
);

    // Scan offsets from the farthest down so the nearest request to ptr wins.
    always_comb begin
        int pos_v;
        pos_v = 0;
        any   = |req;
        index = '0;
        for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
            pos_v = int'(ptr) + off;
            pos_v = (pos_v >= NUM_INPUTS) ? (pos_v - NUM_INPUTS) : pos_v;
            index = req[pos_v] ? SEL_WIDTH'(pos_v) : index;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered AXI-Stream output.
// Optional per-input packet counters are enabled by AXIS_RR_ARBITER_PKT_CNT_EN.
module axis_rr_arbiter
    import arb_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_INPUTS = 4,
    localparam int SEL_WIDTH  = clog2(NUM_INPUTS)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_INPUTS-1:0]            s_valid,
    input  logic [NUM_INPUTS-1:0]            s_last,
    output logic [NUM_INPUTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_last,
    output logic [SEL_WIDTH-1:0]             m_dest,
    output logic                             m_valid,
    input  logic                             m_ready
`ifdef AXIS_RR_ARBITER_PKT_CNT_EN
    ,
    output logic [NUM_INPUTS*PKT_CNT_WIDTH-1:0] pkt_cnt
`endif
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

    arb_state_e              state_r, state_nxt_s;
    logic [SEL_WIDTH-1:0]    grant_r, grant_nxt_s;
    logic [SEL_WIDTH-1:0]    ptr_r, ptr_nxt_s;
    logic                    pick_any_s;
    logic [SEL_WIDTH-1:0]    pick_idx_s;
    logic                    int_ready_s;
    logic                    accept_s;
    logic                    accept_last_s;
    logic [NUM_INPUTS-1:0]   s_ready_s;
    logic [DATA_WIDTH-1:0]   m_data_r;
    logic                    m_last_r;
    logic [SEL_WIDTH-1:0]    m_dest_r;
    logic                    m_valid_r;

    arb_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_pick (
        .req   (s_valid),
        .ptr   (ptr_r),
        .any   (pick_any_s),
        .index (pick_idx_s)
    );

    assign int_ready_s   = ~m_valid_r | m_ready;
    assign accept_s      = (state_r == LOCK) & s_valid[grant_r] & int_ready_s;
    assign accept_last_s = accept_s & s_last[grant_r];

    // Arbitration FSM next-state and per-input ready generation.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        s_ready_s   = '0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = LOCK;
                    grant_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCK: begin
                s_ready_s[grant_r] = int_ready_s;
                if (accept_last_s) begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = (grant_r == LAST_IDX) ? '0 : (grant_r + SEL_WIDTH'(1));
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // One-deep output slice: reloads whenever it is empty or being drained.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
            m_dest_r  <= '0;
        end else if (int_ready_s) begin
            m_valid_r <= accept_s;
            if (accept_s) begin
                m_data_r <= s_data[grant_r*DATA_WIDTH +: DATA_WIDTH];
                m_last_r <= s_last[grant_r];
                m_dest_r <= grant_r;
            end
        end
    end

    assign s_ready = s_ready_s;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign m_dest  = m_dest_r;
    assign m_valid = m_valid_r;

`ifdef AXIS_RR_ARBITER_PKT_CNT_EN
    logic [NUM_INPUTS-1:0][PKT_CNT_WIDTH-1:0] pkt_cnt_r;

    // Completed-packet counters, wrapping naturally at full scale.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_cnt_r <= '0;
        end else if (accept_last_s) begin
            pkt_cnt_r[grant_r] <= pkt_cnt_r[grant_r] + PKT_CNT_WIDTH'(1);
        end
    end

    assign pkt_cnt = pkt_cnt_r;
`endif

endmodule
